// File: rtl/imm_encoder_if.sv
// Request/result bundle for imm_encoder, plus the instruction-type encoding shared with its users.
// Valid/ready: a transfer happens on a rising edge where valid && ready; the sender holds its payload stable while valid && !ready.
`ifndef INSTR_TYPE_BUS
`define INSTR_TYPE_BUS logic [2:0]
`define I_TYPE 3'd0
`define S_TYPE 3'd1
`define B_TYPE 3'd2
`define U_TYPE 3'd3
`define J_TYPE 3'd4
`define R_TYPE 3'd5
`endif
`ifndef REG_BUS
`define REG_BUS logic [63:0]
`endif

interface imm_encoder_if;
    logic                in_valid;
    logic                in_ready;
    `INSTR_TYPE_BUS      in_type;
    `REG_BUS             in_imm;
    logic [31:0]         in_base;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_instr;
    logic                out_err;

    modport master (
        output in_valid, in_type, in_imm, in_base, out_ready,
        input  in_ready, out_valid, out_instr, out_err
    );

    modport slave (
        input  in_valid, in_type, in_imm, in_base, out_ready,
        output in_ready, out_valid, out_instr, out_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Packs a signed 64-bit immediate into the immediate fields of a RISC-V instruction template,
// with one registered output stage, representability checking and saturating statistics.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    logic [63:0] imm;
    logic [31:0] base;
    logic [31:0] packed_instr;
    logic        packed_err;
    logic        in_ready;
    logic        accept;
    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic        out_err_q;

    assign imm  = bus.in_imm;
    assign base = bus.in_base;

    // Register may refill in the same cycle its current result is consumed.
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_err   = out_err_q;

    // Truncated immediate is still packed on error so the caller sees what would be emitted.
    always_comb begin
        packed_instr = base;
        packed_err   = 1'b0;
        case (bus.in_type)
            `I_TYPE: begin
                packed_instr[31:20] = imm[11:0];
                packed_err          = (imm[63:11] != {53{imm[11]}});
            end
            `S_TYPE: begin
                packed_instr[31:25] = imm[11:5];
                packed_instr[11:7]  = imm[4:0];
                packed_err          = (imm[63:11] != {53{imm[11]}});
            end
            `B_TYPE: begin
                packed_instr[31]    = imm[12];
                packed_instr[7]     = imm[11];
                packed_instr[30:25] = imm[10:5];
                packed_instr[11:8]  = imm[4:1];
                packed_err          = (imm[63:12] != {52{imm[12]}}) || imm[0];
            end
            `U_TYPE: begin
                packed_instr[31:12] = imm[31:12];
                packed_err          = (imm[63:31] != {33{imm[31]}}) || (imm[11:0] != 12'h000);
            end
            `J_TYPE: begin
                packed_instr[31]    = imm[20];
                packed_instr[19:12] = imm[19:12];
                packed_instr[20]    = imm[11];
                packed_instr[30:21] = imm[10:1];
                packed_err          = (imm[63:20] != {44{imm[20]}}) || imm[0];
            end
            `R_TYPE: begin
                packed_instr = base;
            end
            default: begin
                packed_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_instr_q <= packed_instr;
            out_err_q   <= packed_err;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_cnt <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            if (enc_cnt != '1) enc_cnt <= enc_cnt + CNT_W'(1);
            if (packed_err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed encodings, backpressure, reset mid-transfer, counter saturation,
// and a randomized run scored against an arithmetic range/decode model.
`timescale 1ns/1ps
`ifndef INSTR_TYPE_BUS
`define INSTR_TYPE_BUS logic [2:0]
`define I_TYPE 3'd0
`define S_TYPE 3'd1
`define B_TYPE 3'd2
`define U_TYPE 3'd3
`define J_TYPE 3'd4
`define R_TYPE 3'd5
`endif

module tb_imm_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_encoder_if bus();
  imm_encoder_if bus4();
  logic [15:0] enc_cnt, err_cnt;
  logic [3:0]  enc_cnt4, err_cnt4;

  imm_encoder #(.CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus), .enc_cnt(enc_cnt), .err_cnt(err_cnt));
  imm_encoder #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .enc_cnt(enc_cnt4), .err_cnt(err_cnt4));

  int checks = 0;
  int failures = 0;
  int unsigned model_enc = 0, model_err = 0;
  int unsigned n4_enc = 0, n4_err = 0;
  int accepts = 0;
  int cyc = 0;
  logic [98:0] exp_q[$];
  logic [98:0] e;
  logic [2:0]  t_e;
  logic [63:0] imm_e;
  logic [31:0] base_e;
  logic        er_e;
  longint      s;
  int          k;
  logic [2:0]  t_r;
  logic [31:0] held_a;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // Representable iff the value lies in the type's signed range and meets its alignment.
  function automatic logic ref_err(input logic [2:0] t, input logic [63:0] imm);
    longint v;
    v = $signed(imm);
    case (t)
      `I_TYPE, `S_TYPE: return (v < -2048) || (v > 2047);
      `B_TYPE: return (v < -4096) || (v > 4095) || (v % 2 != 0);
      `U_TYPE: return (v < -64'sd2147483648) || (v > 64'sd2147483647) || (v % 4096 != 0);
      `J_TYPE: return (v < -1048576) || (v > 1048575) || (v % 2 != 0);
      `R_TYPE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Value the immediate wraps to inside the type's field width (what gets packed).
  function automatic longint trunc(input logic [2:0] t, input logic [63:0] imm);
    longint v;
    v = $signed(imm);
    case (t)
      `I_TYPE, `S_TYPE: return ((v + 2048) & 4095) - 2048;
      `B_TYPE: return (((v + 4096) & 8191) - 4096) & ~64'sd1;
      `U_TYPE: return (((v + 64'sd2147483648) & 64'sd4294967295) - 64'sd2147483648) & ~64'sd4095;
      `J_TYPE: return (((v + 1048576) & 2097151) - 1048576) & ~64'sd1;
      default: return 0;
    endcase
  endfunction

  function automatic longint decode(input logic [2:0] t, input logic [31:0] x);
    logic [11:0] f12;
    logic [12:0] f13;
    logic [19:0] f20;
    logic [20:0] f21;
    case (t)
      `I_TYPE: begin
        f12 = x[31:20];
        return (f12 >= 2048) ? longint'(f12) - 4096 : longint'(f12);
      end
      `S_TYPE: begin
        f12 = {x[31:25], x[11:7]};
        return (f12 >= 2048) ? longint'(f12) - 4096 : longint'(f12);
      end
      `B_TYPE: begin
        f13 = {x[31], x[7], x[30:25], x[11:8], 1'b0};
        return (f13 >= 4096) ? longint'(f13) - 8192 : longint'(f13);
      end
      `U_TYPE: begin
        f20 = x[31:12];
        return ((f20 >= 524288) ? longint'(f20) - 1048576 : longint'(f20)) * 4096;
      end
      `J_TYPE: begin
        f21 = {x[31], x[19:12], x[20], x[30:21], 1'b0};
        return (f21 >= 1048576) ? longint'(f21) - 2097152 : longint'(f21);
      end
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] keep_mask(input logic [2:0] t);
    case (t)
      `I_TYPE: return 32'h000F_FFFF;
      `S_TYPE, `B_TYPE: return 32'h01FF_F07F;
      `U_TYPE, `J_TYPE: return 32'h0000_0FFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic directed(input string tag, input logic [2:0] t, input logic [63:0] imm,
                          input logic [31:0] base, input logic [31:0] ei, input logic ee);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_type = t; bus.in_imm = imm; bus.in_base = base; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_instr"}, bus.out_instr, ei);
    check({tag, "_err"}, bus.out_err, ee);
    model_enc = sat(model_enc, 65535);
    if (ee) model_err = sat(model_err, 65535);
  endtask

  task automatic observe_cycle();
    #1;
    check("in_ready", bus.in_ready, (exp_q.size() == 0) || bus.out_ready);
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      {t_e, imm_e, base_e} = e;
      er_e = ref_err(t_e, imm_e);
      check("rnd_err", bus.out_err, er_e);
      check("rnd_keep", bus.out_instr & keep_mask(t_e), base_e & keep_mask(t_e));
      if (t_e <= `J_TYPE) begin
        check("rnd_field", decode(t_e, bus.out_instr), trunc(t_e, imm_e));
        if (!er_e) check("roundtrip", decode(t_e, bus.out_instr), imm_e);
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back({bus.in_type, bus.in_imm, bus.in_base});
      model_enc = sat(model_enc, 65535);
      if (ref_err(bus.in_type, bus.in_imm)) model_err = sat(model_err, 65535);
      accepts++;
    end
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_type = `I_TYPE; bus.in_imm = '0; bus.in_base = '0; bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_type = `I_TYPE; bus4.in_imm = '0; bus4.in_base = '0; bus4.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_enc_cnt", enc_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;

    // Directed encodings with hand-derived words
    directed("i_m1",    `I_TYPE, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
    directed("i_2047",  `I_TYPE, 64'd2047,                32'h0000_0013, 32'h7FF0_0013, 1'b0);
    directed("i_2048",  `I_TYPE, 64'd2048,                32'h0000_0013, 32'h8000_0013, 1'b1);
    directed("s_m2048", `S_TYPE, 64'hFFFF_FFFF_FFFF_F800, 32'h0000_0023, 32'h8000_0023, 1'b0);
    directed("b_4094",  `B_TYPE, 64'h0000_0000_0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0);
    directed("b_4096",  `B_TYPE, 64'd4096,                32'h0000_0063, 32'h8000_0063, 1'b1);
    directed("b_odd",   `B_TYPE, 64'd3,                   32'h0000_0063, 32'h0000_0163, 1'b1);
    directed("u_neg",   `U_TYPE, 64'hFFFF_FFFF_8000_0000, 32'h0000_0037, 32'h8000_0037, 1'b0);
    directed("u_pos",   `U_TYPE, 64'h0000_0000_8000_0000, 32'h0000_0037, 32'h8000_0037, 1'b1);
    directed("j_max",   `J_TYPE, 64'h0000_0000_000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0);
    directed("r_keep",  `R_TYPE, 64'hDEAD_BEEF_1234_5678, 32'h00B5_0533, 32'h00B5_0533, 1'b0);
    directed("bad_typ", 3'd7,    64'd0,                   32'h1234_5678, 32'h1234_5678, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", bus.out_valid, 0);
    check("dir_enc_cnt", enc_cnt, model_enc);
    check("dir_err_cnt", err_cnt, model_err);

    // Backpressure: A stalls in the output register, B waits until out_ready rises
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_type = `I_TYPE; bus.in_imm = 64'd5; bus.in_base = 32'h0000_0013;
    @(posedge clk); #1;
    bus.in_type = `S_TYPE; bus.in_imm = 64'd3; bus.in_base = 32'h0000_0023;
    held_a = 32'h0050_0013;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_valid", bus.out_valid, 1);
      check("bp_hold", bus.out_instr, held_a);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_b_valid", bus.out_valid, 1);
    check("bp_b_instr", bus.out_instr, 32'h0000_01A3);
    model_enc = sat(model_enc, 65535);
    model_enc = sat(model_enc, 65535);
    check("bp_enc_cnt", enc_cnt, model_enc);
    @(negedge clk);
    @(posedge clk); #1;
    check("bp_no_dup", bus.out_valid, 0);

    // Reset while a result is stalled; a request presented during reset is dropped
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_type = `I_TYPE; bus.in_imm = 64'd1; bus.in_base = 32'h0000_0013;
    @(posedge clk); #1;
    check("rm_pending", bus.out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rm_valid", bus.out_valid, 0);
    check("rm_enc_cnt", enc_cnt, 0);
    check("rm_err_cnt", err_cnt, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rm_stay_idle", bus.out_valid, 0);
    model_enc = 0;
    model_err = 0;

    // Narrow-counter saturation on the CNT_W=4 instance
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 16) begin
        check("c4_enc_16", enc_cnt4, n4_enc);
        check("c4_err_16", err_cnt4, n4_err);
      end
      bus4.in_valid = 1'b1; bus4.in_type = `I_TYPE; bus4.in_base = 32'h0000_0013;
      bus4.in_imm = (i % 2 == 0) ? 64'd5000 : 64'(i);
      n4_enc = sat(n4_enc, 15);
      if (i % 2 == 0) n4_err = sat(n4_err, 15);
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check("c4_enc_sat", enc_cnt4, 4'hF);
    check("c4_err", err_cnt4, n4_err);

    // Randomized traffic scored against the range/decode model
    while (accepts < 10000 && cyc < 40000) begin
      @(negedge clk);
      t_r = 3'($urandom_range(0, 7));
      s = $signed({$urandom, $urandom});
      if ($urandom_range(0, 7) != 0) begin
        k = $urandom_range(1, 40);
        s = (s <<< (64 - k)) >>> (64 - k);
      end
      if ($urandom_range(0, 1) == 1) s = (t_r == `U_TYPE) ? (s & ~64'sd4095) : (s & ~64'sd1);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_type = t_r;
      bus.in_imm = s;
      bus.in_base = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      observe_cycle();
      cyc++;
    end
    check("rnd_budget", accepts >= 10000, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      observe_cycle();
    end
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_enc_cnt", enc_cnt, model_enc);
    check("rnd_err_cnt", err_cnt, model_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
